// File: rtl/sprite_motion.sv
// Per-frame sprite position controller: walk with clamping, jump/gravity/landing, one update per vsync fall.
// Build option: define DOUBLE_JUMP_EN to allow one air jump per airborne period.

module sprite_motion #(
    parameter int SCREEN_W   = 800,
    parameter int SPRITE_W   = 25,
    parameter int SPRITE_H   = 21,
    parameter int FLOOR_Y    = 568,
    parameter int START_X    = 100,
    parameter int START_Y    = 100,
    parameter int WALK_SPEED = 3,
    parameter int JUMP_V     = 8,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 9
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        vsync,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [18:0] pos_x,
    output logic [18:0] pos_y,
    output logic        facing,
    output logic        on_ground,
    output logic        update_done
);

    localparam logic signed [19:0] X_MAX    = 20'(SCREEN_W - SPRITE_W);
    localparam logic signed [19:0] Y_REST   = 20'(FLOOR_Y - SPRITE_H);
    localparam logic signed [19:0] WALK     = 20'(WALK_SPEED);
    localparam logic signed [19:0] HEIGHT   = 20'(SPRITE_H);
    localparam logic signed [19:0] FLOOR    = 20'(FLOOR_Y);
    localparam logic signed [7:0]  JUMP     = 8'(JUMP_V);
    localparam logic signed [7:0]  GRAV     = 8'(GRAVITY);
    localparam logic signed [7:0]  FALL_MAX = 8'(MAX_FALL);

    typedef enum logic [2:0] {S_WAIT, S_HORZ, S_VERT, S_LAND, S_COMMIT} state_t;
    state_t state, state_d;

    logic               vs_meta, vs_sync, vs_last, frame_tick;
    logic               jump_last, jump_rise, jump_pending, jump_pending_d, jump_take;
    logic signed [19:0] x, x_d, y, y_d, y_try, y_try_d, x_sum;
    logic signed [7:0]  vel, vel_d, vel_new;
    logic               facing_d, on_ground_d, jump_ok;

    assign frame_tick = vs_last & ~vs_sync;
    assign jump_rise  = btn_jump & ~jump_last;

`ifdef DOUBLE_JUMP_EN
    logic air_used, air_used_d;
    assign jump_ok = on_ground | ~air_used;
`else
    assign jump_ok = on_ground;
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state;
        x_d         = x;
        y_d         = y;
        y_try_d     = y_try;
        vel_d       = vel;
        facing_d    = facing;
        on_ground_d = on_ground;
        x_sum       = x;
        vel_new     = vel;
        jump_take   = 1'b0;
`ifdef DOUBLE_JUMP_EN
        air_used_d  = air_used;
`endif
        case (state)
            S_WAIT: if (frame_tick) state_d = S_HORZ;
            S_HORZ: begin
                if (btn_left && !btn_right) begin
                    x_sum    = x - WALK;
                    facing_d = 1'b0;
                end else if (btn_right && !btn_left) begin
                    x_sum    = x + WALK;
                    facing_d = 1'b1;
                end
                if (x_sum < 20'sd0)     x_d = '0;
                else if (x_sum > X_MAX) x_d = X_MAX;
                else                    x_d = x_sum;
                state_d = S_VERT;
            end
            S_VERT: begin
                // The pending jump is consumed here whether or not it is accepted.
                jump_take = 1'b1;
                if (jump_pending && jump_ok) begin
                    vel_new = -JUMP;
`ifdef DOUBLE_JUMP_EN
                    if (!on_ground) air_used_d = 1'b1;
`endif
                end else if (on_ground) begin
                    vel_new = '0;
                end else begin
                    vel_new = vel + GRAV;
                    if (vel_new > FALL_MAX) vel_new = FALL_MAX;
                end
                vel_d   = vel_new;
                y_try_d = y + $signed({{12{vel_new[7]}}, vel_new});
                state_d = S_LAND;
            end
            S_LAND: begin
                if (y_try + HEIGHT >= FLOOR) begin
                    y_d         = Y_REST;
                    vel_d       = '0;
                    on_ground_d = 1'b1;
`ifdef DOUBLE_JUMP_EN
                    air_used_d  = 1'b0;
`endif
                end else if (y_try < 20'sd0) begin
                    y_d         = '0;
                    vel_d       = '0;
                    on_ground_d = 1'b0;
                end else begin
                    y_d         = y_try;
                    on_ground_d = 1'b0;
                end
                state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
        jump_pending_d = jump_rise | (jump_pending & ~jump_take);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state        <= S_WAIT;
            vs_meta      <= 1'b1;
            vs_sync      <= 1'b1;
            vs_last      <= 1'b1;
            jump_last    <= 1'b0;
            jump_pending <= 1'b0;
            x            <= 20'(START_X);
            y            <= 20'(START_Y);
            y_try        <= 20'(START_Y);
            vel          <= '0;
            facing       <= 1'b1;
            on_ground    <= 1'b0;
            pos_x        <= 19'(START_X);
            pos_y        <= 19'(START_Y);
            update_done  <= 1'b0;
        end else begin
            state        <= state_d;
            vs_meta      <= vsync;
            vs_sync      <= vs_meta;
            vs_last      <= vs_sync;
            jump_last    <= btn_jump;
            jump_pending <= jump_pending_d;
            x            <= x_d;
            y            <= y_d;
            y_try        <= y_try_d;
            vel          <= vel_d;
            facing       <= facing_d;
            on_ground    <= on_ground_d;
            update_done  <= (state == S_COMMIT);
            if (state == S_COMMIT) begin
                pos_x <= x[18:0];
                pos_y <= y[18:0];
            end
        end
    end

`ifdef DOUBLE_JUMP_EN
    always_ff @(posedge clk) begin
        if (!clrn) air_used <= 1'b0;
        else       air_used <= air_used_d;
    end
`endif

endmodule

// File: tb/tb_sprite_motion.sv
// Self-checking bench for sprite_motion: integer frame model, per-cycle compare process,
// directed physics/clamp/timing cases plus randomized button/jump/vsync stimulus.

module tb_sprite_motion;

    localparam int X_LIMIT = 800 - 25;
    localparam int Y_REST  = 568 - 21;
`ifdef DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    logic        clk = 1'b0, clrn = 1'b0, vsync = 1'b1;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic [18:0] pos_x, pos_y;
    logic        facing, on_ground, update_done;

    sprite_motion dut (
        .clk(clk), .clrn(clrn), .vsync(vsync),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .pos_x(pos_x), .pos_y(pos_y), .facing(facing),
        .on_ground(on_ground), .update_done(update_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: whole-frame physics in plain integers.
    int m_x, m_y, m_vel;
    bit m_facing, m_ground, m_air, m_pending;
    int exp_x, exp_y, stg_x, stg_y, commit_cyc = -1;
    bit exp_face, exp_gnd, stg_face, stg_gnd, in_flight = 1'b0, chk_en = 1'b0;

    task automatic model_reset();
        m_x = 100; m_y = 100; m_vel = 0;
        m_facing = 1'b1; m_ground = 1'b0; m_air = 1'b0; m_pending = 1'b0;
        exp_x = 100; exp_y = 100; exp_face = 1'b1; exp_gnd = 1'b0;
        commit_cyc = -1; in_flight = 1'b0;
    endtask

    task automatic model_frame(input bit l, input bit r);
        int nx, ny;
        nx = m_x;
        if (l && !r)      begin nx = m_x - 3; m_facing = 1'b0; end
        else if (r && !l) begin nx = m_x + 3; m_facing = 1'b1; end
        m_x = (nx < 0) ? 0 : (nx > X_LIMIT) ? X_LIMIT : nx;
        if (m_pending && (m_ground || (DJ && !m_air))) begin
            m_vel = -8;
            if (!m_ground) m_air = 1'b1;
        end else if (m_ground) m_vel = 0;
        else m_vel = (m_vel + 1 > 9) ? 9 : m_vel + 1;
        m_pending = 1'b0;
        ny = m_y + m_vel;
        if (ny + 21 >= 568) begin m_y = Y_REST; m_vel = 0; m_ground = 1'b1; m_air = 1'b0; end
        else if (ny < 0)    begin m_y = 0; m_vel = 0; m_ground = 1'b0; end
        else                begin m_y = ny; m_ground = 1'b0; end
    endtask

    // Compare process: outputs checked every cycle once reset has been applied.
    always @(posedge clk) begin
        bit exp_done;
        #1;
        if (chk_en) begin
            exp_done = 1'b0;
            if (cyc == commit_cyc) begin
                exp_x = stg_x; exp_y = stg_y; exp_face = stg_face; exp_gnd = stg_gnd;
                in_flight = 1'b0; commit_cyc = -1; exp_done = 1'b1;
            end
            check("update_done", update_done, exp_done);
            check("pos_x", pos_x, exp_x);
            check("pos_y", pos_y, exp_y);
            if (!in_flight) begin
                check("facing", facing, exp_face);
                check("on_ground", on_ground, exp_gnd);
            end
        end
    end

    task automatic pulse_jump();
        @(negedge clk);
        btn_jump = 1'b1; m_pending = 1'b1;
        @(negedge clk);
        btn_jump = 1'b0;
    endtask

    // mode: 0 normal, 1 jump edge after vertical step, 2 second vsync fall mid-update, 3 reset mid-update
    task automatic run_frame(input bit l, input bit r, input int mode);
        int c0, lat;
        lat = -1;
        @(negedge clk);
        btn_left = l; btn_right = r;
        c0 = cyc;
        model_frame(l, r);
        stg_x = m_x; stg_y = m_y; stg_face = m_facing; stg_gnd = m_ground;
        commit_cyc = c0 + 7; in_flight = 1'b1;
        vsync = 1'b0;
        while (cyc < c0 + 9) begin
            @(negedge clk);
            if (lat < 0 && update_done === 1'b1) lat = cyc - (c0 + 1);
            if (cyc == c0 + 1) vsync = 1'b1;
            if (mode == 2 && cyc == c0 + 2) vsync = 1'b0;
            if (mode == 2 && cyc == c0 + 4) vsync = 1'b1;
            if (mode == 1 && cyc == c0 + 5) begin btn_jump = 1'b1; m_pending = 1'b1; end
            if (mode == 1 && cyc == c0 + 6) btn_jump = 1'b0;
            if (mode == 3 && cyc == c0 + 4) begin clrn = 1'b0; model_reset(); end
            if (mode == 3 && cyc == c0 + 7) clrn = 1'b1;
        end
        if (mode != 3) check("latency", lat, 6);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        clrn   = 1'b1;
        check("reset pos_x", pos_x, 100);
        check("reset pos_y", pos_y, 100);
        check("reset facing", facing, 1);
        check("reset on_ground", on_ground, 0);
        check("reset update_done", update_done, 0);

        // Free fall from reset.
        run_frame(0, 0, 0); check("fall y1", pos_y, 101);
        run_frame(0, 0, 0); check("fall y2", pos_y, 103);
        run_frame(0, 0, 0); check("fall y3", pos_y, 106);
        for (int i = 0; i < 80 && !m_ground; i++) run_frame(0, 0, 0);
        check("landed y", pos_y, 547);
        check("landed on_ground", on_ground, 1);
        check("fall x unchanged", pos_x, 100);

        // Ground jump, rise, apex, then air jump attempts at vel = +2.
        pulse_jump();
        run_frame(0, 0, 0); check("jump y1", pos_y, 539); check("jump airborne", on_ground, 0);
        run_frame(0, 0, 0); check("jump y2", pos_y, 532);
        repeat (9) run_frame(0, 0, 0);
        check("arc y at vel+2", pos_y, 514);
        pulse_jump();
        run_frame(0, 0, 0); check("second jump y", pos_y, DJ ? 506 : 517);
        pulse_jump();
        run_frame(0, 0, 0); check("third jump y", pos_y, DJ ? 499 : 521);
        for (int i = 0; i < 80 && !m_ground; i++) run_frame(0, 0, 0);
        check("relanded y", pos_y, 547);

        // Jump edge after the vertical step is held for the next frame; extra vsync fall is dropped.
        run_frame(0, 0, 1); check("late jump not applied", pos_y, 547);
        run_frame(0, 0, 2); check("held jump applied", pos_y, 539);
        for (int i = 0; i < 80 && !m_ground; i++) run_frame(0, 0, 0);

        // Reset asserted during the vertical step discards the update.
        run_frame(0, 1, 3);
        check("mid reset pos_x", pos_x, 100);
        check("mid reset pos_y", pos_y, 100);
        check("mid reset facing", facing, 1);

        // Walk right to the clamp, both buttons, then walk left to zero.
        for (int i = 0; i < 300 && m_x != X_LIMIT; i++) run_frame(0, 1, 0);
        run_frame(0, 1, 0);
        check("right clamp x", pos_x, 775); check("right facing", facing, 1);
        run_frame(1, 1, 0);
        check("both held x", pos_x, 775); check("both held facing", facing, 1);
        for (int i = 0; i < 300 && m_x != 0; i++) run_frame(1, 0, 0);
        run_frame(1, 0, 0);
        check("left clamp x", pos_x, 0); check("left facing", facing, 0);
        run_frame(1, 1, 0);
        check("both held facing left", facing, 0);

        // Randomized frames.
        for (int i = 0; i < 150; i++) begin
            int sel;
            if ($urandom_range(0, 3) == 0) pulse_jump();
            sel = $urandom_range(0, 19);
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      (sel == 0) ? 3 : (sel == 1) ? 2 : (sel < 4) ? 1 : 0);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_motion.md
# sprite_motion

Per-frame position controller for the player sprite: the stage directly upstream of the renderer, producing the `pos_x`/`pos_y` coordinates the renderer uses to place the sprite. It samples `vsync` from the VGA timing generator, detects each frame boundary, and runs a short multi-cycle update:
- horizontal walk with screen clamping;
- jump, gravity and landing on a flat floor.

It publishes the new position with a one-cycle `update_done` pulse.

## Interface
Parameters:
- `SCREEN_W`, 800: visible width in pixels.
- `SPRITE_W`, 25: sprite width in pixels.
- `SPRITE_H`, 21: sprite height in pixels.
- `FLOOR_Y`, 568: floor line; the sprite bottom rests at this row.
- `START_X`, 100: reset x position.
- `START_Y`, 100: reset y position.
- `WALK_SPEED`, 3: pixels per frame while walking.
- `JUMP_V`, 8: initial upward speed, pixels per frame.
- `GRAVITY`, 1: added to vertical velocity each airborne frame.
- `MAX_FALL`, 9: downward velocity ceiling.

Ports (clock and reset first):
- `clk` input 1: system clock; every register is clocked on its rising edge.
- `clrn` input 1: reset, synchronous and active-low.
- `vsync` input 1: VGA vertical sync. It comes from the `vga_clk` domain and is asynchronous to `clk`.
- `btn_left` input 1: walk-left level, already debounced.
- `btn_right` input 1: walk-right level, already debounced.
- `btn_jump` input 1: jump level, already debounced.
- `pos_x` output 19: sprite left edge, unsigned.
- `pos_y` output 19: sprite top edge, unsigned.
- `facing` output 1: 1 = facing right, 0 = facing left.
- `on_ground` output 1: the sprite is resting on the floor.
- `update_done` output 1: one-cycle pulse when `pos_x`/`pos_y` take new values.

## Operation
Input conditioning:
- `vsync` passes through a 2-flop synchronizer.
- A falling edge of the synchronized signal generates `frame_tick`.
- `jump_pending` sets on any `btn_jump` rising edge, sampled every `clk`.
- `jump_pending` clears when S_VERT consumes it. If a new edge arrives in that same cycle, the set wins.

State machine:
- S_WAIT: on `frame_tick`, go to S_HORZ. A `frame_tick` arriving outside S_WAIT is dropped.
- S_HORZ:
  - `btn_left` only: x − `WALK_SPEED`, `facing`=0.
  - `btn_right` only: x + `WALK_SPEED`, `facing`=1.
  - Both or neither: x and `facing` unchanged.
  - Clamp the result to [0, `SCREEN_W`−`SPRITE_W`].
  - Go to S_VERT.
- S_VERT, first matching rule applies:
  - Jump accepted (`jump_pending`, and either `on_ground` or an air jump is available): vel = −`JUMP_V`. If not `on_ground`, set `air_used`.
  - Otherwise, if `on_ground`: vel = 0.
  - Otherwise: vel = min(vel+`GRAVITY`, `MAX_FALL`).
  - Then y_next = y + vel (new vel). Go to S_LAND.
- S_LAND, first matching rule applies:
  - y_next + `SPRITE_H` ≥ `FLOOR_Y`: y = `FLOOR_Y`−`SPRITE_H`, vel = 0, `on_ground`=1, `air_used`=0.
  - y_next < 0: y = 0, vel = 0, `on_ground`=0.
  - Otherwise: y = y_next, `on_ground`=0.
  - Go to S_COMMIT.
- S_COMMIT: copy the working x/y to `pos_x`/`pos_y`, pulse `update_done`, return to S_WAIT.

Arithmetic:
- vel is signed 8-bit.
- Working x/y and their sums are signed 20-bit, so underflow and overflow are detected before clamping.
- Outputs are the low 19 bits of clamped, non-negative values.
- `pos_x`/`pos_y` change only in S_COMMIT; the renderer never sees a half-updated position.

## Timing
- Reset values:
  - `pos_x`=`START_X`, `pos_y`=`START_Y`, `facing`=1, `on_ground`=0, `update_done`=0.
  - vel=0, `air_used`=0, `jump_pending`=0, state S_WAIT, synchronizer flops 1.
- Latency: `vsync` falling at `clk` edge N gives `frame_tick` at N+2 (after synchronizer and edge detection). S_HORZ at N+3, `update_done` high and new `pos_*` visible at N+6.
- `update_done` is high for exactly one cycle per accepted frame.
- `clrn` low in any state: every register returns to its reset value at the next `clk` edge and the in-flight update is discarded.
- A jump edge arriving while S_VERT is already past is held for the next frame.

## Configuration
- `DOUBLE_JUMP_EN` defined: one air jump is allowed per airborne period. It is accepted when `!on_ground && !air_used`; `air_used` clears on landing.
- `DOUBLE_JUMP_EN` undefined: jumps are accepted only when `on_ground`. An airborne jump edge still clears `jump_pending` with no effect. The `air_used` register is not built.

## Test plan
- Reset, then free fall: after reset, outputs equal the reset values. Successive ticks give y = 101, 103, 106, … with vel capped at 9. The sprite lands at `pos_y`=547 with `on_ground`=1.
- Ground jump: from rest at 547, a jump pulse then a tick gives y=539, `on_ground`=0. The next tick gives 532.
- Walk clamp: `btn_right` held from x=770 gives x=773, then 775, and stays 775, with `facing`=1. Both buttons held: x unchanged, `facing` unchanged.
- Double jump: airborne at vel=+2, a second jump pulse:
  - with `DOUBLE_JUMP_EN`, vel becomes −8;
  - without it, vel becomes 3;
  - in both cases a third pulse while still airborne has no effect.
- Tick latency, reset mid-update, dropped tick:
  - `update_done` asserts exactly 6 cycles after the `vsync` fall.
  - `clrn`=0 held while in S_VERT: `pos_*`=100/100 and no `update_done` pulse.
  - A second `vsync` fall during the update is ignored.
